// File: rtl/tsv_fault_cfg_ctrl.sv
// Fault-map reconfiguration controller for the 7-TSV CAC/local-AFNS link.
// Optional FAULT_MONOTONIC_EN: new maps are OR-merged with the active map.
module tsv_fault_cfg_ctrl #(
  parameter int unsigned NTSV       = 7,
  parameter int unsigned MAX_FAULTS = 2,
  parameter int unsigned PIPE_LAT   = 3,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic            upd_valid,
  output logic            upd_ready,
  input  logic [NTSV-1:0] upd_flags,
  input  logic            src_valid,
  output logic            src_ready,
  output logic            code_en,
  output logic [NTSV-1:0] f_flag,
  output logic [2:0]      fault_cnt,
  output logic            cfg_busy,
  output logic            cfg_done,
  output logic            cfg_err
);

  localparam int unsigned DCNT_W = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
  localparam int unsigned SCNT_W = $clog2(SETTLE_CYC + 1);

  localparam logic [DCNT_W-1:0] DCNT_LD = DCNT_W'(PIPE_LAT);
  localparam logic [SCNT_W-1:0] SCNT_LD = SCNT_W'(SETTLE_CYC - 1);
  localparam logic [2:0]        MAX_F   = 3'(MAX_FAULTS);

  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_APPLY  = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [NTSV-1:0]   shadow;
  logic [NTSV-1:0]   capture;
  logic [2:0]        shadow_cnt;
  logic              over_cap;
  logic [DCNT_W-1:0] dcnt;
  logic [SCNT_W-1:0] scnt;
  logic              run_q;

  function automatic logic [2:0] popcount(input logic [NTSV-1:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int unsigned i = 0; i < NTSV; i++) c = c + 3'(v[i]);
    return c;
  endfunction

`ifdef FAULT_MONOTONIC_EN
  // Faults are permanent: a TSV once marked faulty is never re-enabled.
  assign capture = upd_flags | f_flag;
`else
  assign capture = upd_flags;
`endif

  assign shadow_cnt = popcount(shadow);
  assign over_cap   = shadow_cnt > MAX_F;

  // Handshakes come from a registered RUN flag so reset can hold them low.
  assign upd_ready = run_q;
  assign src_ready = run_q;
  assign code_en   = src_valid & run_q;
  assign cfg_busy  = state != ST_RUN;

  always_ff @(posedge clock) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_RUN:    if (upd_valid && upd_ready) next_state = ST_CHECK;
      ST_CHECK:  next_state = over_cap ? ST_RUN : ST_DRAIN;
      ST_DRAIN:  if (dcnt == '0) next_state = ST_APPLY;
      ST_APPLY:  next_state = ST_SETTLE;
      ST_SETTLE: if (scnt == '0) next_state = ST_RUN;
      default:   next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      shadow    <= '0;
      f_flag    <= '0;
      fault_cnt <= 3'd0;
      cfg_err   <= 1'b0;
      cfg_done  <= 1'b0;
      dcnt      <= '0;
      scnt      <= '0;
    end else begin
      run_q    <= next_state == ST_RUN;
      cfg_done <= (state == ST_SETTLE) && (scnt == '0);

      if (upd_valid && upd_ready) shadow <= capture;

      // Words accepted by the coder need PIPE_LAT cycles to leave the link.
      if (code_en)          dcnt <= DCNT_LD;
      else if (dcnt != '0)  dcnt <= dcnt - DCNT_W'(1);

      case (state)
        ST_CHECK: cfg_err <= over_cap;
        ST_APPLY: begin
          f_flag    <= shadow;
          fault_cnt <= shadow_cnt;
          scnt      <= SCNT_LD;
        end
        ST_SETTLE: if (scnt != '0) scnt <= scnt - SCNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule
